// File: rtl/usb_rx_data_buffer.sv
// usb_rx_data_buffer: receive-side byte FIFO between the USB receiver and the
// protocol/AHB consumer. Occupancy is a standalone up/down counter. full, empty
// and the sticky overflow/underflow flags are all registered.
// Optional feature macro: RX_BUF_ALMOST_FULL_EN adds a registered almost_full
// output that asserts when occupancy >= AF_THRESHOLD.
module usb_rx_data_buffer #(
  parameter int DEPTH        = 64,
  parameter int CNT_W        = $clog2(DEPTH) + 1,
  parameter int AF_THRESHOLD = DEPTH - 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             w_enable,
  input  logic [7:0]       w_data,
  input  logic             r_enable,
  output logic [7:0]       r_data,
  output logic [CNT_W-1:0] buffer_occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow,
`ifdef RX_BUF_ALMOST_FULL_EN
  output logic             almost_full,
`endif
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full, r_empty, r_ovf, r_udf;
  logic [7:0]       r_rdata;
  logic             w_rd_ok, w_wr_ok;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Acceptance is decided on the registered state. A full buffer can take a
  // write only when a read drains it in the same cycle. An empty buffer never
  // forwards the write to the read side. Flush suppresses both requests.
  assign w_rd_ok = r_enable & ~r_empty & ~flush;
  assign w_wr_ok = w_enable & (~r_full | w_rd_ok) & ~flush;

  // Next occupancy; simultaneous accepted read and write leave it unchanged
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_cnt_nxt = r_cnt + ONE_CNT;
      2'b01:   w_cnt_nxt = r_cnt - ONE_CNT;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Storage array; contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= w_data;
  end

  // Pointers, counter, status and read data
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_rdata <= 8'h00;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) begin
        r_rptr  <= r_rptr + AW'(1);
        r_rdata <= r_mem[r_rptr];
      end
      if (w_enable && !w_wr_ok) r_ovf <= 1'b1;
      if (r_enable && !w_rd_ok) r_udf <= 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

`ifdef RX_BUF_ALMOST_FULL_EN
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_THRESHOLD);
  logic r_af;

  // Early-NAK indication tracking the updated occupancy
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     r_af <= 1'b0;
    else if (flush) r_af <= 1'b0;
    else            r_af <= (w_cnt_nxt >= AF_CNT);
  end

  assign almost_full = r_af;
`endif

  assign r_data           = r_rdata;
  assign buffer_occupancy = r_cnt;
  assign full             = r_full;
  assign empty            = r_empty;
  assign overflow         = r_ovf;
  assign underflow        = r_udf;
endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Scoreboard bench for usb_rx_data_buffer (DEPTH=64). Each read the stimulus
// issues pushes the byte r_data must show afterwards. The monitor pops and
// compares on the falling edge after the read edge.
module tb_usb_rx_data_buffer;
  logic       clk = 1'b0;
  logic       n_rst, flush, w_enable, r_enable;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [6:0] buffer_occupancy;
  logic       full, empty, overflow, underflow;
`ifdef RX_BUF_ALMOST_FULL_EN
  logic       almost_full;
`endif

  int ncmp = 0;
  int nfail = 0;
  logic [7:0] sb[$];
  logic       rd_seen = 1'b0;

  usb_rx_data_buffer #(.DEPTH(64)) dut (
    .clk(clk), .n_rst(n_rst), .flush(flush),
    .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
    .r_data(r_data), .buffer_occupancy(buffer_occupancy),
    .full(full), .empty(empty), .overflow(overflow),
`ifdef RX_BUF_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: flag every cycle that issued a read, compare r_data half a cycle later
  always @(posedge clk) rd_seen <= r_enable && n_rst && !flush;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) chk("sb_underrun", 1, 0);
      else chk("r_data", int'(r_data), int'(sb.pop_front()));
    end
  end

  // One clock with the given request; inputs change 1 time unit after the edge
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    w_enable = we; w_data = wd; r_enable = re; flush = fl;
    @(posedge clk); #1;
    w_enable = 1'b0; r_enable = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] exp);
    sb.push_back(exp);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_occ"},   int'(buffer_occupancy), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"},  int'(full), 0);
    chk({tag, "_ovf"},   int'(overflow), 0);
    chk({tag, "_udf"},   int'(underflow), 0);
    chk({tag, "_rdata"}, int'(r_data), 0);
`ifdef RX_BUF_ALMOST_FULL_EN
    chk({tag, "_af"},    int'(almost_full), 0);
`endif
  endtask

  initial begin
    n_rst = 1'b0; flush = 1'b0; w_enable = 1'b0; r_enable = 1'b0; w_data = 8'h00;
    #12;
    chk_rst("reset");
    @(posedge clk); #1; n_rst = 1'b1;
    @(posedge clk); #1;

    // 1: two bytes in, two bytes out
    wr(8'hA5); wr(8'h3C);
    chk("t1_occ2", int'(buffer_occupancy), 2);
    chk("t1_empty0", int'(empty), 0);
    rd(8'hA5); rd(8'h3C);
    chk("t1_occ0", int'(buffer_occupancy), 0);
    chk("t1_empty1", int'(empty), 1);

    // 2: fill, overrun, drain in order
    for (int i = 0; i < 64; i++) wr(8'(i));
    chk("t2_full", int'(full), 1);
    chk("t2_occ64", int'(buffer_occupancy), 64);
    chk("t2_ovf0", int'(overflow), 0);
    wr(8'hFF);
    chk("t2_ovf1", int'(overflow), 1);
    chk("t2_occ_hold", int'(buffer_occupancy), 64);
    for (int i = 0; i < 64; i++) rd(8'(i));
    chk("t2_empty", int'(empty), 1);
    chk("t2_full0", int'(full), 0);

    // 3: simultaneous read/write at full
    for (int i = 0; i < 64; i++) wr(8'(i));
    sb.push_back(8'h00);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t3_occ64", int'(buffer_occupancy), 64);
    chk("t3_full", int'(full), 1);
    for (int i = 1; i < 64; i++) rd(8'(i));
    rd(8'h77);
    chk("t3_empty", int'(empty), 1);

    // 4: simultaneous read/write when empty: read rejected, r_data holds
    chk("t4_udf0", int'(underflow), 0);
    sb.push_back(8'h77);
    cyc(1'b1, 8'h42, 1'b1, 1'b0);
    chk("t4_udf1", int'(underflow), 1);
    chk("t4_occ1", int'(buffer_occupancy), 1);
    rd(8'h42);
    chk("t4_empty", int'(empty), 1);
    chk("t4_udf_sticky", int'(underflow), 1);

    // 5: flush beats a same-cycle write; then wrap-around traffic
    for (int i = 0; i < 10; i++) wr(8'(8'h10 + i));
    chk("t5_occ10", int'(buffer_occupancy), 10);
    chk("t5_ovf_sticky", int'(overflow), 1);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("t5_occ0", int'(buffer_occupancy), 0);
    chk("t5_empty", int'(empty), 1);
    chk("t5_ovf0", int'(overflow), 0);
    chk("t5_udf0", int'(underflow), 0);
    chk("t5_rdata_kept", int'(r_data), 8'h42);
    for (int i = 0; i < 100; i++) begin
      wr(8'(i * 3 + 1));
      rd(8'(i * 3 + 1));
    end
    chk("t5_wrap_empty", int'(empty), 1);
    chk("t5_wrap_ovf", int'(overflow), 0);
    chk("t5_wrap_udf", int'(underflow), 0);

`ifdef RX_BUF_ALMOST_FULL_EN
    // 6: almost_full threshold at 60
    for (int i = 0; i < 59; i++) wr(8'(8'h80 + i));
    chk("t6_af0", int'(almost_full), 0);
    wr(8'hBB);
    chk("t6_af1", int'(almost_full), 1);
    rd(8'h80);
    chk("t6_af_clr", int'(almost_full), 0);
`else
    for (int i = 0; i < 30; i++) wr(8'(8'h80 + i));
    chk("t6_occ30", int'(buffer_occupancy), 30);
`endif

    // Asynchronous reset mid-burst
    w_enable = 1'b1; w_data = 8'hEE;
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk_rst("midrst");
    w_enable = 1'b0;
    @(posedge clk); #1; n_rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", int'(empty), 1);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
